// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_receiver
// Description : Serial-to-parallel receiver. Assembles sync-framed, MSB-first
//               strobed serial bits into bit_size-bit words and presents each
//               completed word on a held output with a valid/ready handshake.
//               Reports dropped words (sticky overrun) and aborted words
//               (one-cycle frame_err pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_receiver #(
  parameter int bit_size = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sin,
  input  logic                sin_en,
  input  logic                sync,
  input  logic                dout_ready,
  input  logic                ovr_clr,
  output logic [bit_size-1:0] dout,
  output logic                dout_valid,
  output logic                overrun,
  output logic                frame_err,
  output logic                busy
);

  localparam int              c_cnt_w = $clog2(bit_size + 1);
  localparam logic [0:0]      c_idle  = 1'b0;
  localparam logic [0:0]      c_recv  = 1'b1;
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(bit_size - 1);

  logic [0:0]          state_q, state_d;
  // Only the bit_size-1 most recent bits are stored; the incoming bit is
  // appended combinationally, so the completed word is available on the
  // completing edge without an extra cycle.
  logic [bit_size-2:0] shreg_q, shreg_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [bit_size-1:0] dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                overrun_q, overrun_d;
  logic                frame_err_q, frame_err_d;

  logic [bit_size-1:0] w_word;
  logic                w_last;
  logic                w_word_done;

  assign w_word      = {shreg_q, sin};
  assign w_last      = (cnt_q == c_last);
  assign w_word_done = (state_q == c_recv) && sin_en && !sync && w_last;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= c_idle;
      shreg_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state: a sync-qualified bit starts a word; the last bit ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_idle:  if (sin_en && sync) state_d = c_recv;
      c_recv:  if (w_word_done)    state_d = c_idle;
      default: state_d = c_idle;
    endcase
  end

  // Shifting, bit counting, output buffer, handshake and error flags.
  always_comb begin
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    frame_err_d  = 1'b0;

    case (state_q)
      c_idle: begin
        if (sin_en && sync) begin
          shreg_d = w_word[bit_size-2:0];
          cnt_d   = c_one;
        end
      end
      c_recv: begin
        if (sin_en) begin
          shreg_d = w_word[bit_size-2:0];
          if (sync) begin
            // Early sync: abandon the partial word and restart on this bit.
            cnt_d       = c_one;
            frame_err_d = 1'b1;
          end else if (w_last) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + c_one;
          end
        end
      end
      default: ;
    endcase

    // Clear first so that a simultaneous set takes priority.
    if (ovr_clr) overrun_d = 1'b0;

    if (w_word_done) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = w_word;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == c_recv);

endmodule
`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_receiver
// Description : Directed bench for serial_word_receiver (bit_size = 8) with a
//               scoreboard of expected delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b0;
  logic       sin_en = 1'b0;
  logic       sync = 1'b0;
  logic       dout_ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  serial_word_receiver #(.bit_size(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_en     (sin_en),
    .sync       (sync),
    .dout_ready (dout_ready),
    .ovr_clr    (ovr_clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change on the falling edge, results read 1 ns after rise.
  task automatic tick(input logic b_sin, input logic b_en, input logic b_sync);
    @(negedge clk);
    sin    = b_sin;
    sin_en = b_en;
    sync   = b_sync;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit ready_on_last);
    for (int i = 0; i < 8; i++) begin
      if (ready_on_last && i == 7) dout_ready = 1'b1;
      tick(w[7-i], 1'b1, (i == 0));
    end
  endtask

  // Scoreboard: a handshake happens on an edge where valid && ready, so the
  // pair is sampled just before the rising edge.
  always @(negedge clk) begin
    #4;
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {24'h0, dout}, 32'hxxxx_xxxx);
      end else begin
        chk("sb_word", {24'h0, dout}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] w;
    logic [3:0] part;

    // Reset state
    #1;
    chk("rst_dout", {24'h0, dout}, 32'h0);
    chk("rst_valid", {31'h0, dout_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ovr", {31'h0, overrun}, 32'h0);
    chk("rst_ferr", {31'h0, frame_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: plain word, consumer always ready
    dout_ready = 1'b1;
    exp_q.push_back(8'hA5);
    send_word(8'hA5, 1'b0);
    chk("a5_dout", {24'h0, dout}, 32'hA5);
    chk("a5_valid", {31'h0, dout_valid}, 32'h1);
    chk("a5_ovr", {31'h0, overrun}, 32'h0);
    chk("a5_ferr", {31'h0, frame_err}, 32'h0);
    chk("a5_busy_done", {31'h0, busy}, 32'h0);
    tick(1'b0, 1'b0, 1'b0);
    chk("a5_valid_one_cycle", {31'h0, dout_valid}, 32'h0);

    // 2: gap of 3 strobe-less cycles between bits 4 and 5
    w = 8'h3C;
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      tick(w[7-i], 1'b1, (i == 0));
      if (i == 3) begin
        for (int g = 0; g < 3; g++) begin
          tick(1'b1, 1'b0, 1'b0);
          chk("gap_busy", {31'h0, busy}, 32'h1);
          chk("gap_no_valid", {31'h0, dout_valid}, 32'h0);
        end
      end
    end
    chk("3c_dout", {24'h0, dout}, 32'h3C);
    chk("3c_valid", {31'h0, dout_valid}, 32'h1);
    tick(1'b0, 1'b0, 1'b0);

    // 3: overrun when the held word is not taken
    dout_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_word(8'h11, 1'b0);
    chk("ovr_first_dout", {24'h0, dout}, 32'h11);
    chk("ovr_first_ovr", {31'h0, overrun}, 32'h0);
    send_word(8'h22, 1'b0);
    chk("ovr_hold_dout", {24'h0, dout}, 32'h11);
    chk("ovr_set", {31'h0, overrun}, 32'h1);
    chk("ovr_hold_valid", {31'h0, dout_valid}, 32'h1);
    tick(1'b0, 1'b0, 1'b0);
    chk("ovr_sticky", {31'h0, overrun}, 32'h1);
    ovr_clr = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    ovr_clr = 1'b0;
    chk("ovr_cleared", {31'h0, overrun}, 32'h0);
    chk("ovr_valid_kept", {31'h0, dout_valid}, 32'h1);
    dout_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    chk("ovr_valid_drop", {31'h0, dout_valid}, 32'h0);

    // 4: accept on the same edge a new word completes
    dout_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_word(8'h11, 1'b0);
    exp_q.push_back(8'h22);
    send_word(8'h22, 1'b1);
    chk("sim_dout", {24'h0, dout}, 32'h22);
    chk("sim_valid", {31'h0, dout_valid}, 32'h1);
    chk("sim_ovr", {31'h0, overrun}, 32'h0);
    tick(1'b0, 1'b0, 1'b0);
    chk("sim_valid_drop", {31'h0, dout_valid}, 32'h0);

    // 5: early sync aborts a partial word
    part = 4'b1011;
    for (int i = 0; i < 4; i++) tick(part[3-i], 1'b1, (i == 0));
    chk("fe_busy_partial", {31'h0, busy}, 32'h1);
    w = 8'hF0;
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      tick(w[7-i], 1'b1, (i == 0));
      if (i == 0) chk("fe_pulse", {31'h0, frame_err}, 32'h1);
      if (i == 1) chk("fe_one_cycle", {31'h0, frame_err}, 32'h0);
      if (i < 7) chk("fe_no_early_word", {31'h0, dout_valid}, 32'h0);
    end
    chk("fe_dout", {24'h0, dout}, 32'hF0);
    chk("fe_valid", {31'h0, dout_valid}, 32'h1);
    tick(1'b0, 1'b0, 1'b0);

    // 6: asynchronous reset mid-word with a held word
    dout_ready = 1'b0;
    exp_q.push_back(8'h55);
    send_word(8'h55, 1'b0);
    chk("pre_rst_dout", {24'h0, dout}, 32'h55);
    w = 8'hC3;
    for (int i = 0; i < 5; i++) tick(w[7-i], 1'b1, (i == 0));
    sin_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_dout", {24'h0, dout}, 32'h0);
    chk("arst_valid", {31'h0, dout_valid}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_ovr", {31'h0, overrun}, 32'h0);
    chk("arst_ferr", {31'h0, frame_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    dout_ready = 1'b1;
    exp_q.push_back(8'h81);
    send_word(8'h81, 1'b0);
    chk("post_rst_dout", {24'h0, dout}, 32'h81);
    chk("post_rst_valid", {31'h0, dout_valid}, 32'h1);
    tick(1'b0, 1'b0, 1'b0);

    // Strobed bits without sync are ignored in IDLE
    for (int i = 0; i < 8; i++) begin
      tick(i[0], 1'b1, 1'b0);
      chk("nosync_busy", {31'h0, busy}, 32'h0);
      chk("nosync_valid", {31'h0, dout_valid}, 32'h0);
    end
    tick(1'b0, 1'b0, 1'b0);
    chk("sb_drained", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
Serial-to-parallel receiver: the far end of the parallel-load/serial-shift transmit chain. It accepts a strobed, MSB-first serial bit stream framed by a start-of-word sync, and assembles bit_size-bit words. Each completed word is presented on a double-buffered output with a valid/ready handshake. Framing and overrun errors are reported. It sits between a serial link input and a word-wide consumer, in the same clock domain.

Parameters:
bit_size, 8, word width in bits; legal range 2..32.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
sin  input  1  serial data bit; sampled only when sin_en=1.
sin_en  input  1  bit strobe; one serial bit per clk cycle where sin_en=1.
sync  input  1  start-of-word marker; qualified by sin_en; marks the current sin as the word MSB.
dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
ovr_clr  input  1  synchronous clear of the sticky overrun flag.
dout  output  bit_size  received word; first received bit is at dout[bit_size-1].
dout_valid  output  1  dout holds an unconsumed word.
overrun  output  1  sticky: a completed word was dropped.
frame_err  output  1  one-cycle pulse: a word was aborted by an early sync.
busy  output  1  high while in RECV.

Behaviour:
- Reset (async, rst=1): state=IDLE, shift register=0, bit counter=0, dout=0, dout_valid=0, overrun=0, frame_err=0, busy=0. Reset mid-word discards the partial word. Reset also discards any held output word.
- Shift rule: on each accepted bit, shreg <= {shreg[bit_size-2:0], sin}. bit_size accepted bits therefore put the first bit in the MSB.
- Bit counter: width clog2(bit_size+1); counts accepted bits of the current word.
- FSM states: IDLE, RECV.
- IDLE, sin_en=1 and sync=1: shift in sin, count=1, go RECV.
- IDLE, sin_en=1 and sync=0: bit ignored; stay in IDLE.
- IDLE, sin_en=0: hold.
- RECV, sin_en=0: hold all state. Gaps of any length are allowed.
- RECV, sin_en=1 and sync=0: shift in sin, count+1.
  - If this is bit number bit_size, the word completes: go IDLE, count=0.
- RECV, sin_en=1 and sync=1: resync. frame_err pulses 1 on the next cycle. The partial word is discarded. The current bit becomes the new MSB, count=1, stay in RECV.
- Word completion uses the value shifted in on the completing edge. At that same edge:
  - If dout_valid=0, or dout_valid=1 with dout_ready=1: dout <= completed word, dout_valid=1.
  - If dout_valid=1 with dout_ready=0: the new word is dropped, dout keeps the old word, overrun <= 1.
- Latency: the 8th (bit_size-th) accepted bit is sampled at edge N. dout/dout_valid are visible after edge N, with zero extra cycles.
- Handshake: when dout_valid=1 and dout_ready=1 and no word completes, dout_valid <= 0 and dout holds its value.
  - dout must remain stable while dout_valid=1 and dout_ready=0.
  - dout_ready is ignored while dout_valid=0.
- Simultaneous accept and completion: dout_valid stays 1 and dout takes the new word. No bubble, no overrun.
- Double buffering: the next word may begin receiving while dout is held.
- overrun: set as above; cleared only by rst or ovr_clr=1.
  - If set and clear happen on the same edge, set wins.
- frame_err: registered, high for exactly one cycle per resync event.
- busy = (state == RECV).

Test Plan:
- bit_size=8, dout_ready=1, stream 0xA5 MSB-first on 8 consecutive sin_en cycles, sync on bit 0 -> after edge 8, dout=0xA5 and dout_valid=1 for exactly 1 cycle; overrun=0, frame_err=0.
- Same word 0x3C with sin_en deasserted for 3 cycles between bits 4 and 5 -> dout=0x3C; busy=1 throughout the gap.
- dout_ready=0, send 0x11 then 0x22 -> dout stays 0x11, overrun=1 after the 2nd word. Pulse ovr_clr -> overrun=0. Raise dout_ready -> dout_valid drops.
- dout_ready=0, send 0x11. Assert dout_ready exactly on the edge completing 0x22 -> dout=0x22, dout_valid stays 1, overrun=0.
- Send 4 bits 1,0,1,1, then sync with new word 0xF0 -> frame_err pulses 1 cycle; dout=0xF0; no word output for the aborted bits.
- Drive rst asynchronously after 5 bits while dout_valid=1 holds 0x55 -> all outputs 0 immediately. A later sync-framed 0x81 is received correctly. sin_en bits without sync in IDLE produce no output.
